// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// resolves EX/MEM and MEM/WB forwarding, and inserts bubbles on flush and load-use hazards.
module id_ex_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [1:0]        id_aluOP,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_ctrl,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        ex_aluOP,
    output logic [5:0]        ex_sel,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic [3:0]        ex_ctrl,
    output logic              load_use_haz
);

    logic              ex_valid_r;
    logic [4:0]        ex_ctrl_r;     // {regwrite, memread, memwrite, memtoreg, alusrc}
    logic [1:0]        ex_aluop_r;
    logic [5:0]        ex_sel_r;
    logic [REG_AW-1:0] ex_dest_r;
    logic [REG_AW-1:0] ex_rs_r;
    logic [REG_AW-1:0] ex_rt_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [DATA_W-1:0] imm_r;

    logic              load_use_haz_s;
    logic              bubble_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    // Youngest producer wins; r0 is never forwarded since it reads as zero.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic [DATA_W-1:0] mw_res
    );
        logic [DATA_W-1:0] val;
        if (em_we && (em_rd != '0) && (em_rd == src)) begin
            val = em_res;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
            val = mw_res;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Load-use detection against the instruction currently waiting in ID.
    always_comb begin
        load_use_haz_s = ex_valid_r && ex_ctrl_r[3] && (ex_dest_r != '0) && id_valid &&
                         ((ex_dest_r == id_rs) || (ex_dest_r == id_rt));
        bubble_s       = flush || (!stall && (load_use_haz_s || !id_valid));
    end

    // Stage register: flush beats stall, stall beats hazard, hazard beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= 5'b0;
            ex_aluop_r <= 2'b0;
            ex_sel_r   <= 6'b0;
            ex_dest_r  <= '0;
            ex_rs_r    <= '0;
            ex_rt_r    <= '0;
            rs_data_r  <= '0;
            rt_data_r  <= '0;
            imm_r      <= '0;
        end else if (bubble_s) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= 5'b0;
            ex_aluop_r <= 2'b0;
            ex_sel_r   <= 6'b0;
            ex_dest_r  <= '0;
        end else if (!stall) begin
            ex_valid_r <= 1'b1;
            ex_ctrl_r  <= id_ctrl;
            ex_aluop_r <= id_aluOP;
            ex_sel_r   <= id_funct;
            ex_dest_r  <= id_dest;
            ex_rs_r    <= id_rs;
            ex_rt_r    <= id_rt;
            rs_data_r  <= id_rs_data;
            rt_data_r  <= id_rt_data;
            imm_r      <= id_imm;
        end
    end

    // Operand forwarding and immediate selection into the ALU.
    always_comb begin
        fwd_rs_s = fwd_sel(ex_rs_r, rs_data_r, exmem_regwrite, exmem_rd, exmem_result,
                           memwb_regwrite, memwb_rd, memwb_result);
        fwd_rt_s = fwd_sel(ex_rt_r, rt_data_r, exmem_regwrite, exmem_rd, exmem_result,
                           memwb_regwrite, memwb_rd, memwb_result);
        if (ex_ctrl_r[0]) begin
            alu_b = imm_r;
        end else begin
            alu_b = fwd_rt_s;
        end
        alu_a         = fwd_rs_s;
        ex_store_data = fwd_rt_s;
    end

    assign ex_valid     = ex_valid_r;
    assign ex_aluOP     = ex_aluop_r;
    assign ex_sel       = ex_sel_r;
    assign ex_dest      = ex_dest_r;
    assign ex_ctrl      = ex_ctrl_r[4:1];
    assign load_use_haz = load_use_haz_s;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed plus randomized bench for id_ex_pipe_stage, checked against a
// transaction-level model of the EX slot built from the stage's priority rules.
module tb_id_ex_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [1:0]  id_aluOP;
    logic [5:0]  id_funct;
    logic [4:0]  id_ctrl;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, load_use_haz;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [1:0]  ex_aluOP;
    logic [5:0]  ex_sel;
    logic [4:0]  ex_dest;
    logic [3:0]  ex_ctrl;

    int errors = 0;
    int checks = 0;

    id_ex_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_aluOP(id_aluOP), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .ex_aluOP(ex_aluOP),
        .ex_sel(ex_sel), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_ctrl(ex_ctrl), .load_use_haz(load_use_haz)
    );

    always #5 clk = ~clk;

    // What the EX slot should hold: one instruction (or nothing) with its operands.
    typedef struct {
        logic        valid;
        logic [4:0]  ctrl;
        logic [1:0]  aluop;
        logic [5:0]  sel;
        logic [4:0]  dest, rs, rt;
        logic [31:0] rsd, rtd, imm;
    } slot_t;
    slot_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (src != 5'd0 && exmem_regwrite && exmem_rd == src) return exmem_result;
        if (src != 5'd0 && memwb_regwrite && memwb_rd == src) return memwb_result;
        return rf;
    endfunction

    function automatic logic ref_haz();
        return m.valid && m.ctrl[3] && m.dest != 5'd0 && id_valid &&
               (m.dest == id_rs || m.dest == id_rt);
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
        chk({tag, ".ctrl"}, {28'd0, ex_ctrl}, {28'd0, m.ctrl[4:1]});
        chk({tag, ".aluop"}, {30'd0, ex_aluOP}, {30'd0, m.aluop});
        chk({tag, ".sel"}, {26'd0, ex_sel}, {26'd0, m.sel});
        chk({tag, ".haz"}, {31'd0, load_use_haz}, {31'd0, ref_haz()});
        if (m.valid) begin
            chk({tag, ".dest"}, {27'd0, ex_dest}, {27'd0, m.dest});
            chk({tag, ".alu_a"}, alu_a, ref_fwd(m.rs, m.rsd));
            chk({tag, ".alu_b"}, alu_b, m.ctrl[0] ? m.imm : ref_fwd(m.rt, m.rtd));
            chk({tag, ".store"}, ex_store_data, ref_fwd(m.rt, m.rtd));
        end
    endtask

    // One clock edge: predict the slot from the inputs seen at the edge, then compare.
    task automatic tick(input string tag);
        slot_t nx;
        nx = m;
        if (flush || (!stall && (ref_haz() || !id_valid))) begin
            nx.valid = 1'b0; nx.ctrl = 5'd0; nx.aluop = 2'd0; nx.sel = 6'd0;
        end else if (!stall) begin
            nx = '{valid: 1'b1, ctrl: id_ctrl, aluop: id_aluOP, sel: id_funct,
                   dest: id_dest, rs: id_rs, rt: id_rt,
                   rsd: id_rs_data, rtd: id_rt_data, imm: id_imm};
        end
        @(posedge clk);
        #1;
        m = nx;
        check_state(tag);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [1:0] op, input logic [5:0] fn, input logic [4:0] ctl);
        id_valid = v; id_rs = rs; id_rt = rt; id_dest = dst;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_aluOP = op; id_funct = fn; id_ctrl = ctl;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 6'd0, 5'd0);
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
        m = '{default: '0};
        #12;
        chk("rst.valid", {31'd0, ex_valid}, 32'd0);
        chk("rst.ctrl", {28'd0, ex_ctrl}, 32'd0);
        chk("rst.aluop", {30'd0, ex_aluOP}, 32'd0);
        chk("rst.sel", {26'd0, ex_sel}, 32'd0);
        chk("rst.dest", {27'd0, ex_dest}, 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.alu_b", alu_b, 32'd0);
        chk("rst.store", ex_store_data, 32'd0);
        rst_n = 1'b1;

        // add r3 = r1 + r2
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 2'b10, 6'b100000, 5'b10000);
        tick("add");
        chk("add.a5", alu_a, 32'd5);
        chk("add.b7", alu_b, 32'd7);
        chk("add.sel", {26'd0, ex_sel}, 32'h20);

        // forwarding priority on rs=r1
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 6'd0, 5'd0);
        exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h10;
        memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'h20;
        #1 chk("fwd.exmem_wins", alu_a, 32'h10);
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 chk("fwd.r0_none", alu_a, 32'd5);
        memwb_rd = 5'd1;
        #1 chk("fwd.memwb", alu_a, 32'h20);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        #1 check_state("fwd.off");

        // lw r4, then add r5 = r4 + r6 -> one bubble
        set_id(1'b1, 5'd1, 5'd4, 5'd4, 32'd100, 32'd0, 32'd4, 2'b11, 6'd0, 5'b11011);
        tick("lw");
        set_id(1'b1, 5'd4, 5'd6, 5'd5, 32'd9, 32'd3, 32'd0, 2'b10, 6'b100000, 5'b10000);
        #1 chk("lu.haz", {31'd0, load_use_haz}, 32'd1);
        tick("lu.bubble");
        chk("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu.bubble_ctrl", {28'd0, ex_ctrl}, 32'd0);
        tick("lu.add");
        chk("lu.add_valid", {31'd0, ex_valid}, 32'd1);

        // sub held through a 3-cycle stall, then flush+stall
        set_id(1'b1, 5'd7, 5'd8, 5'd9, 32'd50, 32'd20, 32'd0, 2'b01, 6'b100010, 5'b10000);
        tick("sub");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                   5'($urandom_range(1, 31)), $urandom, $urandom, $urandom,
                   2'($urandom), 6'($urandom), 5'($urandom));
            tick("stall");
            chk("stall.aluop", {30'd0, ex_aluOP}, 32'd1);
        end
        flush = 1'b1;
        tick("flush_stall");
        chk("flush_stall.valid", {31'd0, ex_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // sw with alusrc: imm to ALU, MEM/WB-forwarded rt to store data
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 32'h99, 32'd8, 2'b11, 6'd0, 5'b00101);
        memwb_regwrite = 1'b1; memwb_rd = 5'd2; memwb_result = 32'hAB;
        tick("sw");
        chk("sw.alu_b", alu_b, 32'd8);
        chk("sw.store", ex_store_data, 32'hAB);
        memwb_regwrite = 1'b0;

        // asynchronous reset between edges
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 32'd1, 32'd2, 32'd3, 2'b10, 6'h24, 5'b10000);
        tick("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        m = '{default: '0};
        chk("arst.valid", {31'd0, ex_valid}, 32'd0);
        chk("arst.ctrl", {28'd0, ex_ctrl}, 32'd0);
        chk("arst.dest", {27'd0, ex_dest}, 32'd0);
        #2 rst_n = 1'b1;

        // randomized traffic on a small register set to provoke forwarding and hazards
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_id(($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom, 2'($urandom), 6'($urandom), 5'($urandom));
            exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_result = $urandom;
            #1 check_state("rnd.pre");
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
